// File: rtl/func_share_arbiter.sv
// Shares one combinational A/B/C/D evaluator between two requesters: IDLE -> EVAL -> DONE.
// Optional build macro FUNC_SHARE_RR_EN selects round-robin tie-breaking instead of fixed priority to requester 0.
module func_share_arbiter #(
  parameter int OPW = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           req0,
  input  logic [OPW-1:0] op0,
  input  logic           req1,
  input  logic [OPW-1:0] op1,
  output logic           ack0,
  output logic           ack1,
  output logic           y0,
  output logic           y1,
  output logic           busy,
  output logic [OPW-1:0] fu_abcd,
  input  logic           fu_y
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [OPW-1:0] fu_abcd_q;
  logic           win_q;
  logic           ack0_q;
  logic           ack1_q;
  logic           y0_q;
  logic           y1_q;
  logic           busy_q;
  logic           grant_s;
  logic           win_s;
`ifdef FUNC_SHARE_RR_EN
  // Index of the requester favoured on the next tie.
  logic           prio_q;
`endif

  // Winner selection: a lone request wins, ties follow the configured policy.
  always_comb begin
    grant_s = req0 | req1;
    win_s   = 1'b0;
    if (req0 && req1) begin
`ifdef FUNC_SHARE_RR_EN
      win_s = prio_q;
`else
      win_s = 1'b0;
`endif
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      fu_abcd_q <= '0;
      win_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      y0_q      <= 1'b0;
      y1_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FUNC_SHARE_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            fu_abcd_q <= win_s ? op1 : op0;
            win_q     <= win_s;
            busy_q    <= 1'b1;
            state_q   <= ST_EVAL;
`ifdef FUNC_SHARE_RR_EN
            prio_q    <= ~win_s;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          // fu_abcd has been stable for a full cycle, so fu_y is settled here.
          if (win_q) begin
            y1_q   <= fu_y;
            ack1_q <= 1'b1;
          end else begin
            y0_q   <= fu_y;
            ack0_q <= 1'b1;
          end
          busy_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign y0      = y0_q;
  assign y1      = y1_q;
  assign busy    = busy_q;
  assign fu_abcd = fu_abcd_q;

endmodule

// File: tb/tb_func_share_arbiter.sv
// Self-checking bench for func_share_arbiter: vector table with a result scoreboard plus hand-written corner sequences.
module tb_func_share_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req0 = 1'b0;
  logic [3:0] op0 = 4'b0000;
  logic       req1 = 1'b0;
  logic [3:0] op1 = 4'b0000;
  logic       ack0, ack1, y0, y1, busy, fu_y;
  logic [3:0] fu_abcd;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] sb_q[$];
  logic [1:0] ym = 2'b00;

  typedef struct packed {
    logic       req0;
    logic [3:0] op0;
    logic       req1;
    logic [3:0] op1;
    logic       exp_win;
    logic       exp_y;
  } vec_t;

  vec_t vecs[8];

  always #5 CLK = ~CLK;

  // Evaluator model.
  assign fu_y = ^fu_abcd;

  func_share_arbiter #(.OPW(4)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .op0(op0), .req1(req1), .op1(op1),
    .ack0(ack0), .ack1(ack1), .y0(y0), .y1(y1), .busy(busy),
    .fu_abcd(fu_abcd), .fu_y(fu_y)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_y0", 32'(y0), 32'd0);
    check("rst_y1", 32'(y1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fu_abcd", 32'(fu_abcd), 32'd0);
    RST = 1'b0;
    ym = 2'b00;
  endtask

  task automatic run_txn(input vec_t v);
    logic [1:0] e;
    logic       got;
    int         lat;
    got = 1'b0;
    lat = -1;
    sb_q.push_back({v.exp_win, v.exp_y});
    req0 = v.req0; op0 = v.op0; req1 = v.req1; op1 = v.op1;
    step();
    check("eval_busy", 32'(busy), 32'd1);
    check("eval_fu_abcd", 32'(fu_abcd), 32'(v.exp_win ? v.op1 : v.op0));
    for (int k = 0; k < 4; k++) begin
      step();
      if (ack0 || ack1) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    check("ack_latency", 32'(lat), 32'd0);
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("ack0", 32'(ack0), 32'(!e[1]));
      check("ack1", 32'(ack1), 32'(e[1]));
      check("y_winner", 32'(e[1] ? y1 : y0), 32'(e[0]));
      check("y_loser", 32'(e[1] ? y0 : y1), 32'(e[1] ? ym[0] : ym[1]));
      ym[e[1]] = e[0];
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check("idle_acks", 32'({ack1, ack0}), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
`ifdef FUNC_SHARE_RR_EN
    vecs[0] = '{1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 4'b0000, 1'b1, 4'b0110, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'b0001, 1'b1, 4'b0011, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
`else
    vecs[0] = '{1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 4'b0000, 1'b1, 4'b0110, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
`endif

    // Reset values, then a quiet idle period.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      check("idle_busy_quiet", 32'(busy), 32'd0);
      check("idle_fu_quiet", 32'(fu_abcd), 32'd0);
    end

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Continuous tie: acks every 3 cycles, alternating only with round-robin.
    do_reset();
    req0 = 1'b1; op0 = 4'b0001; req1 = 1'b1; op1 = 4'b0011;
    for (int k = 1; k <= 9; k++) begin
      step();
`ifdef FUNC_SHARE_RR_EN
      check("tie_ack0", 32'(ack0), 32'((k == 2) || (k == 8)));
      check("tie_ack1", 32'(ack1), 32'(k == 5));
      if (k == 5) check("tie_y1", 32'(y1), 32'd0);
`else
      check("tie_ack0", 32'(ack0), 32'((k % 3) == 2));
      check("tie_ack1", 32'(ack1), 32'd0);
`endif
      if (k == 2) check("tie_y0", 32'(y0), 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Back-to-back requester 1 with a new operand in the ack cycle.
    do_reset();
    req1 = 1'b1; op1 = 4'b0111;
    step();
    check("b2b_fu1", 32'(fu_abcd), 32'h7);
    step();
    check("b2b_ack1_first", 32'(ack1), 32'd1);
    check("b2b_y1_first", 32'(y1), 32'd1);
    op1 = 4'b1111;
    step();
    check("b2b_gap_ack1", 32'(ack1), 32'd0);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    step();
    check("b2b_fu2", 32'(fu_abcd), 32'hf);
    step();
    check("b2b_ack1_second", 32'(ack1), 32'd1);
    check("b2b_y1_second", 32'(y1), 32'd0);
    check("b2b_ack0", 32'(ack0), 32'd0);
    req1 = 1'b0;
    step();

    // Reset pulsed during EVAL aborts the transaction.
    do_reset();
    run_txn('{1'b1, 4'b1011, 1'b0, 4'b0000, 1'b0, 1'b1});
    req0 = 1'b1; op0 = 4'b0001;
    step();
    check("abort_busy_eval", 32'(busy), 32'd1);
    RST = 1'b1;
    step();
    check("abort_ack0", 32'(ack0), 32'd0);
    check("abort_y0", 32'(y0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fu", 32'(fu_abcd), 32'd0);
    RST = 1'b0; req0 = 1'b0;
    step();
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_ack0", 32'(ack0), 32'd0);
    step();
    check("abort_late_ack0", 32'(ack0), 32'd0);

    // Requester 1 request dropped before it could be granted.
    req0 = 1'b1; op0 = 4'b0010;
    step();
    req1 = 1'b1; op1 = 4'b0001;
    step();
    check("drop_ack0", 32'(ack0), 32'd1);
    check("drop_y0", 32'(y0), 32'd1);
    check("drop_ack1_done", 32'(ack1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("drop_busy", 32'(busy), 32'd0);
      check("drop_ack1", 32'(ack1), 32'd0);
      check("drop_y1", 32'(y1), 32'd0);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/func_share_arbiter.md
# func_share_arbiter

- Shares one combinational evaluator (the `ejemplo_00` function, A/B/C/D → Y) between two requesters instead of instantiating it twice.
- Arbitrates, registers the winning operand into the evaluator, captures its result and returns it with a one-cycle acknowledge.
- Sits in `top` between the button-derived operand sources and a single `ejemplo_00` instance; its per-requester result registers drive PIN_14 and PIN_16.

## Interface
- `OPW`, default 4: operand width; bit order {A,B,C,D}, MSB = A.
- `CLK` input, 1: system clock; all logic is on the rising edge.
- `RST` input, 1: reset, synchronous, active-high.
- `req0` input, 1: request from requester 0.
- `op0` input, OPW: operand of requester 0.
- `req1` input, 1: request from requester 1.
- `op1` input, OPW: operand of requester 1.
- `ack0` output, 1: one-cycle pulse when the requester 0 result is valid.
- `ack1` output, 1: one-cycle pulse when the requester 1 result is valid.
- `y0` output, 1: last result for requester 0; held until its next completion.
- `y1` output, 1: last result for requester 1; held until its next completion.
- `busy` output, 1: high whenever the state is not IDLE.
- `fu_abcd` output, OPW: registered operand driven to the shared evaluator.
- `fu_y` input, 1: combinational result from the shared evaluator.

## Operation
- FSM states: IDLE → EVAL → DONE → IDLE.
- **IDLE**
  - Requests are sampled only in this state.
  - If no request: stay in IDLE.
  - If any request: select a winner, load `fu_abcd` ← winner's operand, record the winner index, go to EVAL.
- **EVAL**
  - `fu_abcd` is stable; `fu_y` settles combinationally.
  - On the edge: capture `fu_y` into the winner's y register, go to DONE.
- **DONE**
  - `ack` of the winner is high for exactly this cycle; then go to IDLE.
  - The loser's y and ack are untouched.
- **Requester rule**
  - Hold `req` and `op` stable from assertion until the ack cycle.
  - During the ack cycle, either drop `req` or present a new `op`.
  - `req` still high in the following IDLE is a new transaction.
- **Arbitration**
  - Single request: it wins.
  - Both requesting: winner is set by the priority policy (see Configuration).
  - A request dropped before grant is legal and simply not served.
- `fu_abcd` keeps the last granted operand while in IDLE. There is no evaluator traffic when idle.

## Timing
- Latency: request seen in IDLE at cycle n → `fu_abcd` valid in cycle n+1 → `y`/`ack` valid in cycle n+2.
- Throughput: one transaction per 3 cycles; maximum 1/3 of CLK rate.
- Reset values: state IDLE, `fu_abcd` = 0, `ack0` = `ack1` = 0, `y0` = `y1` = 0, `busy` = 0, round-robin pointer favors requester 0.
- **Reset mid-transaction** (EVAL or DONE): abort.
  - No ack is issued; the y registers clear to 0.
  - The requester re-requests after reset.
- **Evaluator timing constraint:** the `fu_abcd` → `fu_y` path must settle within one CLK period.
- **Simultaneous events:**
  - A new request arriving during EVAL or DONE waits for IDLE.
  - Both acks are never high in the same cycle.

## Configuration
- Macro: `FUNC_SHARE_RR_EN`.
- **Defined:** round-robin arbitration.
  - On a tie, the winner is the requester that did not win the most recent grant.
  - The pointer updates on every grant.
  - After reset, requester 0 wins the first tie.
- **Undefined:** fixed priority.
  - Requester 0 always wins a tie.
  - No pointer register exists; requester 1 can starve.

## Test plan
The bench models the evaluator as `fu_y = ^fu_abcd`.
1. **Reset values:** assert `RST` 2 cycles → all outputs 0, `busy` 0; release, no requests for 5 cycles → `busy` stays 0, `fu_abcd` stays 4'b0000.
2. **Single request:** `req0`=1, `op0`=4'b1011 in IDLE at cycle n → `fu_abcd`=4'b1011 at n+1, `ack0`=1 and `y0`=1 at n+2, `ack1` stays 0, `y1` unchanged.
3. **Tie with `FUNC_SHARE_RR_EN`:** both requests held, `op0`=4'b0001, `op1`=4'b0011 → `ack0` first (`y0`=1), then `ack1` 3 cycles later (`y1`=0), alternating on every further tie. Without the macro, requester 0 is always served and `ack1` never asserts while `req0` stays high.
4. **Back-to-back:** `req1` held with `op1` changed to 4'b1111 in the ack cycle → second `ack1` exactly 3 cycles after the first, with `y1`=0.
5. **Reset in EVAL:** `RST` pulsed in cycle n+1 of a requester 0 transaction → no `ack0`, `y0`=0, state IDLE the cycle after reset deasserts.
6. **Request dropped before grant:** `req1` raised during EVAL of a requester 0 transaction, dropped in DONE → no requester 1 grant, `busy` returns to 0.
